fill_ctrl: RTL and testbench



---
 rtl/fill_ctrl.sv | 151 +++++++++++++++
 tb/tb_fill_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_ctrl.sv
// Bottle-filling station controller: index, settle, fill to level, hand off to sealing, release on VE.
// Optional FILL_COUNT_SAT_EN: COUNT saturates at all-ones instead of wrapping.
module fill_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int FILL_TIMEOUT = 200,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             PG,
    input  logic             NIVEL,
    input  logic             VE,
    input  logic             ACK,
    output logic             MOTOR,
    output logic             VALV,
    output logic             CH,
    output logic             ERRO,
    output logic [CNT_W-1:0] COUNT,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE   = 3'd1,
        SETTLE = 3'd2,
        FILL   = 3'd3,
        DONE   = 3'd4,
        EXIT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam int TMAX = (SETTLE_CYC > FILL_TIMEOUT) ? SETTLE_CYC : FILL_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          stop_req, stop_req_n;
    logic          cnt_inc;
    logic          settle_done;
    logic          fill_timeout;

    // The PG cycle seen in MOVE is the first settle cycle, so SETTLE itself
    // holds SETTLE_CYC-1 cycles (at least one).
    assign settle_done  = (int'(timer) + 2 >= SETTLE_CYC);
    assign fill_timeout = (int'(timer) == FILL_TIMEOUT - 1);
    assign dbg_state    = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            timer    <= '0;
            stop_req <= 1'b0;
            COUNT    <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            stop_req <= stop_req_n;
            if (cnt_inc) begin
`ifdef FILL_COUNT_SAT_EN
                if (COUNT != '1) COUNT <= COUNT + 1'b1;
`else
                COUNT <= COUNT + 1'b1;
`endif
            end
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        stop_req_n = stop_req;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (START && !STOP) state_n = MOVE;
            end
            MOVE: begin
                if (STOP) begin
                    state_n = IDLE;
                end else if (PG) begin
                    state_n = SETTLE;
                    timer_n = '0;
                end
            end
            SETTLE: begin
                if (STOP) begin
                    state_n = IDLE;
                end else if (!PG) begin
                    state_n = MOVE;
                end else if (settle_done) begin
                    state_n = FILL;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            FILL: begin
                if (STOP) stop_req_n = 1'b1;
                // Level reached wins over a lost bottle or the timeout cycle.
                if (NIVEL) begin
                    state_n = DONE;
                    cnt_inc = 1'b1;
                end else if (!PG || fill_timeout) begin
                    state_n = FAULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                if (VE) state_n = EXIT;
            end
            EXIT: begin
                if (!PG) begin
                    if (stop_req || STOP) begin
                        state_n    = IDLE;
                        stop_req_n = 1'b0;
                    end else begin
                        state_n = MOVE;
                    end
                end
            end
            FAULT: begin
                stop_req_n = 1'b0;
                if (ACK) state_n = IDLE;
            end
            default: begin
                state_n    = IDLE;
                timer_n    = '0;
                stop_req_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        MOTOR = 1'b0;
        VALV  = 1'b0;
        CH    = 1'b0;
        ERRO  = 1'b0;
        case (state)
            MOVE:    MOTOR = 1'b1;
            FILL:    VALV  = 1'b1;
            DONE:    CH    = 1'b1;
            EXIT:    MOTOR = 1'b1;
            FAULT:   ERRO  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fill_ctrl.sv
// Bench for fill_ctrl: directed scenarios plus random stimulus, checked every cycle
// against a behavioural model of the station (counts of consecutive PG and FILL cycles).
module tb_fill_ctrl;

    localparam int S    = 3;
    localparam int T    = 10;
    localparam int W    = 2;
    localparam int CMAX = (1 << W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_CONV  = 1;
    localparam int M_SETL  = 2;
    localparam int M_FILL  = 3;
    localparam int M_FULL  = 4;
    localparam int M_LEAVE = 5;
    localparam int M_FLT   = 6;

    logic clk = 1'b0;
    logic rst, start, stop, pg, nivel, ve, ack;
    logic motor, valv, ch, erro;
    logic [W-1:0] count;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    int m_mode, m_pg_run, m_fill_cyc, m_count;
    bit m_stop;

    fill_ctrl #(.SETTLE_CYC(S), .FILL_TIMEOUT(T), .CNT_W(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .PG(pg), .NIVEL(nivel),
        .VE(ve), .ACK(ack), .MOTOR(motor), .VALV(valv), .CH(ch), .ERRO(erro),
        .COUNT(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int bump(input int c);
`ifdef FILL_COUNT_SAT_EN
        return (c == CMAX) ? CMAX : c + 1;
`else
        return (c + 1) % (CMAX + 1);
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = M_IDLE; m_stop = 0; m_count = 0; m_pg_run = 0; m_fill_cyc = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (start && !stop) m_mode = M_CONV;
            M_CONV: begin
                if (stop) m_mode = M_IDLE;
                else if (pg) begin m_mode = M_SETL; m_pg_run = 1; end
            end
            M_SETL: begin
                if (stop) m_mode = M_IDLE;
                else if (!pg) m_mode = M_CONV;
                else begin
                    m_pg_run++;
                    if (m_pg_run >= S) begin m_mode = M_FILL; m_fill_cyc = 0; end
                end
            end
            M_FILL: begin
                if (stop) m_stop = 1;
                m_fill_cyc++;
                if (nivel) begin m_mode = M_FULL; m_count = bump(m_count); end
                else if (!pg || m_fill_cyc >= T) m_mode = M_FLT;
            end
            M_FULL: if (ve) m_mode = M_LEAVE;
            M_LEAVE: begin
                if (!pg) begin
                    if (m_stop || stop) begin m_mode = M_IDLE; m_stop = 0; end
                    else m_mode = M_CONV;
                end
            end
            M_FLT: begin
                m_stop = 0;
                if (ack) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("motor", motor, (m_mode == M_CONV || m_mode == M_LEAVE));
        check("valv",  valv,  (m_mode == M_FILL));
        check("ch",    ch,    (m_mode == M_FULL));
        check("erro",  erro,  (m_mode == M_FLT));
        check("count", count, m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; stop = 0; pg = 0; nivel = 0; ve = 0; ack = 0;
        tick(); tick();
        check("rst_outs", {motor, valv, ch, erro}, 4'b0000);
        check("rst_count", count, 0);
        rst = 0;
    endtask

    // Drive one bottle through to release; nivel rises in the 2nd FILL cycle.
    task automatic complete_one();
        start = 1; stop = 0; pg = 1; ve = 0; ack = 0;
        for (int i = 0; i < 20 && m_mode != M_FULL; i++) begin
            nivel = (m_mode == M_FILL && m_fill_cyc == 1);
            tick();
        end
        nivel = 0;
        check("reach_done", ch, 1);
        ve = 1; tick(); ve = 0;
        pg = 0; tick();
    endtask

    initial begin
        int vcnt;
        rst = 1; start = 0; stop = 0; pg = 0; nivel = 0; ve = 0; ack = 0;
        m_mode = M_IDLE; m_stop = 0; m_count = 0; m_pg_run = 0; m_fill_cyc = 0;
        #1;
        do_reset();

        // Nominal cycle
        start = 1; tick(); tick(); tick(); tick();
        check("moving", motor, 1);
        pg = 1; tick();
        check("motor_falls", motor, 0);
        vcnt = 0;
        for (int i = 0; i < 11; i++) begin
            nivel = (m_mode == M_FILL && m_fill_cyc == 3);
            tick();
            if (valv) vcnt++;
        end
        nivel = 0;
        check("valv_len", vcnt, 4);
        check("ch_hold", ch, 1);
        check("count_one", count, 1);
        ve = 1; tick(); ve = 0;
        check("exit_motor", motor, 1);
        pg = 0; tick();
        check("back_move", motor, 1);

        // Timeout, then NIVEL on exactly the last allowed cycle
        pg = 1;
        for (int i = 0; i < 13; i++) tick();
        check("timeout_erro", erro, 1);
        check("timeout_valv", valv, 0);
        check("timeout_count", count, 1);
        tick(); tick();
        check("fault_holds", erro, 1);
        ack = 1; tick(); ack = 0;
        check("ack_clears", erro, 0);
        for (int i = 0; i < 16 && m_mode != M_FULL; i++) begin
            nivel = (m_mode == M_FILL && m_fill_cyc == T - 1);
            tick();
        end
        nivel = 0;
        check("edge_done", ch, 1);
        check("edge_no_fault", erro, 0);
        check("edge_count", count, 2);
        ve = 1; tick(); ve = 0; pg = 0; tick();

        // Bottle lost in SETTLE, then in FILL
        vcnt = 0;
        pg = 1; tick(); tick(); pg = 0; tick();
        if (valv) vcnt++;
        check("settle_lost_motor", motor, 1);
        check("settle_no_valv", vcnt, 0);
        pg = 1; tick(); tick(); tick(); tick();
        check("in_fill", valv, 1);
        pg = 0; tick();
        check("fill_lost_fault", erro, 1);
        ack = 1; tick(); ack = 0; tick();

        // Stop handling
        check("pre_stop_move", motor, 1);
        stop = 1; tick(); stop = 0;
        check("stop_in_move", motor, 0);
        pg = 1;
        for (int i = 0; i < 5; i++) tick();
        check("stop_fill_valv", valv, 1);
        stop = 1; tick(); stop = 0;
        for (int i = 0; i < 8 && m_mode != M_FULL; i++) begin
            nivel = (m_mode == M_FILL && m_fill_cyc == 3);
            tick();
        end
        nivel = 0;
        check("stop_fill_done", ch, 1);
        tick(); tick();
        check("stop_wait_ve", ch, 1);
        ve = 1; tick(); ve = 0; pg = 0; tick();
        check("stop_to_idle", motor, 0);
        start = 1; stop = 1; tick(); tick(); tick();
        check("start_stop_idle", motor, 0);
        stop = 0;

        // Reset mid-fill; RST between edges has no effect until the edge
        pg = 1;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_valv", valv, 1);
        rst = 1; #2;
        check("rst_not_yet", valv, 1);
        tick(); rst = 0;
        check("rst_mid_outs", {motor, valv, ch, erro}, 4'b0000);
        check("rst_mid_count", count, 0);

        // Counter boundary: four completions
        for (int i = 0; i < 4; i++) complete_one();
`ifdef FILL_COUNT_SAT_EN
        check("count_boundary", count, CMAX);
`else
        check("count_boundary", count, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 1) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            pg    = ($urandom_range(0, 5) != 0);
            nivel = ($urandom_range(0, 5) == 0);
            ve    = ($urandom_range(0, 2) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
